uart_rx_fifo: RTL

Receive-side buffer between the UART receiver and the APB register interface. It accepts bytes from the receiver's valid/ready output and stores them in a circular buffer, which the APB read path drains. It raises a level (threshold) interrupt, a character-timeout interrupt, and a sticky overrun flag. The timeout uses the same baud divisor as the receiver, so the timeout interval follows the configured line rate.

---
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive buffer. Circular byte FIFO between the receiver and
//            the APB read path. Provides a level interrupt, a character
//            timeout interrupt paced by the baud divisor, and a sticky overrun
//            flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int BUFFER_DEPTH     = 16,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clr_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  input  logic [15:0]                 cfg_div_i,
  input  logic [1:0]                  cfg_trig_i,
  output logic                        irq_thr_o,
  output logic                        irq_timeout_o,
  output logic                        overrun_o
);

  localparam int CW = LOG_BUFFER_DEPTH + 1;

  localparam logic [CW-1:0] c_DEPTH    = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] c_ONE      = CW'(1);
  localparam logic [CW-1:0] c_THR_QTR  = CW'(BUFFER_DEPTH / 4);
  localparam logic [CW-1:0] c_THR_HALF = CW'(BUFFER_DEPTH / 2);
  localparam logic [CW-1:0] c_THR_HIGH = CW'(BUFFER_DEPTH - 2);
  // Four 10-bit characters worth of bit periods.
  localparam logic [5:0]    c_BITS_MAX = 6'd40;

  logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic                        r_overrun;
  logic [15:0]                 r_presc;
  logic [5:0]                  r_bits;
  logic                        r_irq_timeout;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_write;
  logic          w_drop;
  logic          w_tmo_rst;
  logic          w_tick;
  logic [CW-1:0] w_thr;

  // The receiver is never stalled; a byte that does not fit is dropped.
  assign ready_o = 1'b1;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_push  = valid_i & ready_o;
  assign w_pop   = ~w_empty & ready_i;
  // A simultaneous pop frees the slot, so a full FIFO still accepts then.
  assign w_write = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  assign data_o     = r_mem[r_rd_ptr];
  assign valid_o    = ~w_empty;
  assign elements_o = r_count;

  // Threshold decode for the level interrupt.
  always_comb begin
    w_thr = c_ONE;
    case (cfg_trig_i)
      2'b00:   w_thr = c_ONE;
      2'b01:   w_thr = c_THR_QTR;
      2'b10:   w_thr = c_THR_HALF;
      default: w_thr = c_THR_HIGH;
    endcase
  end

  assign irq_thr_o = (r_count >= w_thr);

  // Byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_write && !clr_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers and fill count; flush wins over any push or pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + c_ONE;
      end else if (!w_write && w_pop) begin
        r_count <= r_count - c_ONE;
      end
    end
  end

  // Sticky overrun, set by a dropped byte and cleared only by flush.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_overrun <= 1'b0;
    end else if (clr_i) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun_o = r_overrun;

  // Any FIFO activity, a flush or an empty FIFO restarts the idle timer.
  assign w_tmo_rst = w_push | w_pop | clr_i | w_empty;
  // Equality compare: lowering the divisor mid-count wraps through 0xFFFF.
  assign w_tick    = (r_presc == cfg_div_i);

  // Bit-period prescaler and saturating bit-period counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_presc <= '0;
      r_bits  <= '0;
    end else if (w_tmo_rst) begin
      r_presc <= '0;
      r_bits  <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_bits != c_BITS_MAX) begin
        r_bits <= r_bits + 6'd1;
      end
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Registered timeout interrupt; activity clears it on the following edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_irq_timeout <= 1'b0;
    end else if (clr_i || w_push || w_pop) begin
      r_irq_timeout <= 1'b0;
    end else if ((r_bits == c_BITS_MAX) && !w_empty) begin
      r_irq_timeout <= 1'b1;
    end
  end

  assign irq_timeout_o = r_irq_timeout;

endmodule
`default_nettype wire
